// File: rtl/stream_pkt_fifo_pkg.sv
// stream_pkt_fifo_pkg
//   Shared types for the store-and-forward packet FIFO.
//   rd_state_e : read-side FSM state (idle / streaming committed packets).
`timescale 1ns/1ps
package stream_pkt_fifo_pkg;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

endpackage

// File: rtl/sdp_ram.sv
// sdp_ram
//   Simple dual-port RAM: one write port, one read port with registered output.
//   Ports:
//     clk              clock
//     wr_en/addr/data  write port (data stored on the rising edge)
//     rd_en/addr       read request; rd_data is valid the cycle after rd_en
//     rd_data          registered read data
`timescale 1ns/1ps
module sdp_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/stream_pkt_fifo.sv
// stream_pkt_fifo
//   Store-and-forward packet FIFO for data/last/valid/ready streams. A packet
//   becomes visible on the master port only after its last beat is written,
//   and m_valid never drops inside a packet. Packets flagged with s_drop on
//   the last beat, or larger than the buffer, are discarded.
//   Ports:
//     clk, rst                     clock, asynchronous active-high reset
//     s_data/s_last/s_drop         ingress beat, end of packet, discard flag
//     s_valid/s_ready              ingress handshake
//     m_data/m_last                egress beat
//     m_valid/m_ready              egress handshake
//     pkt_count                    complete packets stored, not yet fully read
//     drop_pulse                   one-cycle pulse per discarded packet
`timescale 1ns/1ps
module stream_pkt_fifo
  import stream_pkt_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_last,
  input  logic                    s_drop,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [$clog2(DEPTH):0]  pkt_count,
  output logic                    drop_pulse
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int PW         = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       wr_commit_q, wr_commit_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       pkt_count_q, pkt_count_d;
  logic                discard_q, discard_d;
  logic                drop_pulse_q, drop_pulse_d;
  logic                en_q;
  rd_state_e           state_q, state_d;
  logic [DATA_WIDTH:0] skid0_q, skid0_d, skid1_q, skid1_d;
  logic [1:0]          skid_cnt_q, skid_cnt_d;
  logic                rd_pending_q, rd_pending_d;

  logic                full, oversize, discard_eff, s_hs, wr_en, commit;
  logic                pop, dec, fetch, fetch_room, stream_en;
  logic [1:0]          occupancy;
  logic [DATA_WIDTH:0] ram_rd_data;

  // ---------------- write side ----------------
  assign full = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
  // Buffer full of a single unfinished packet: nothing can ever drain, so
  // switch to swallowing the rest of it. Acting combinationally keeps
  // s_ready high across the transition.
  assign oversize    = full & (wr_commit_q == rd_ptr_q) & ~discard_q;
  assign discard_eff = discard_q | oversize;
  assign s_ready     = en_q & (~full | discard_eff);
  assign s_hs        = s_valid & s_ready;
  assign wr_en       = s_hs & ~discard_eff;
  assign commit      = wr_en & s_last & ~s_drop;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    wr_commit_d  = wr_commit_q;
    discard_d    = discard_q;
    drop_pulse_d = 1'b0;
    if (oversize) begin
      wr_ptr_d  = wr_commit_q;
      discard_d = 1'b1;
    end
    if (s_hs) begin
      if (discard_eff) begin
        if (s_last) begin
          discard_d    = 1'b0;
          drop_pulse_d = 1'b1;
        end
      end else if (s_last && s_drop) begin
        wr_ptr_d     = wr_commit_q;
        drop_pulse_d = 1'b1;
      end else if (s_last) begin
        wr_ptr_d    = wr_ptr_q + PTR_ONE;
        wr_commit_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
    end
  end

  // ---------------- read side ----------------
  assign m_valid = skid_cnt_q != 2'd0;
  assign m_data  = skid0_q[DATA_WIDTH-1:0];
  assign m_last  = skid0_q[DATA_WIDTH];
  assign pop     = m_valid & m_ready;
  assign dec     = pop & skid0_q[DATA_WIDTH];

  // Beats held in the skid plus the one in flight out of the RAM must never
  // exceed the two skid slots.
  assign occupancy  = skid_cnt_q + {1'b0, rd_pending_q};
  assign fetch_room = (occupancy < 2'd2) | (pop & (occupancy == 2'd2));
  // Fetch already in the cycle IDLE decides to leave, saving a cycle of latency.
  assign stream_en  = (state_q == RD_STREAM) | (pkt_count_q != '0);
  assign fetch      = stream_en & (rd_ptr_q != wr_commit_q) & fetch_room;

  assign rd_ptr_d     = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, fetch};
  assign rd_pending_d = fetch;

  always_comb begin
    pkt_count_d = pkt_count_q;
    case ({commit, dec})
      2'b10:   pkt_count_d = pkt_count_q + PTR_ONE;
      2'b01:   pkt_count_d = pkt_count_q - PTR_ONE;
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  // Two-entry output skid; skid0 is the head presented on the master port.
  always_comb begin
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    skid_cnt_d = skid_cnt_q;
    case (skid_cnt_q)
      2'd0: begin
        if (rd_pending_q) begin
          skid0_d    = ram_rd_data;
          skid_cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (pop && rd_pending_q) begin
          skid0_d = ram_rd_data;
        end else if (pop) begin
          skid_cnt_d = 2'd0;
        end else if (rd_pending_q) begin
          skid1_d    = ram_rd_data;
          skid_cnt_d = 2'd2;
        end
      end
      default: begin
        if (pop && rd_pending_q) begin
          skid0_d = skid1_q;
          skid1_d = ram_rd_data;
        end else if (pop) begin
          skid0_d    = skid1_q;
          skid_cnt_d = 2'd1;
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_IDLE:   if (pkt_count_q != '0) state_d = RD_STREAM;
      RD_STREAM: if (dec && (pkt_count_d == '0)) state_d = RD_IDLE;
      default:   state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      wr_commit_q  <= '0;
      rd_ptr_q     <= '0;
      pkt_count_q  <= '0;
      discard_q    <= 1'b0;
      drop_pulse_q <= 1'b0;
      en_q         <= 1'b0;
      state_q      <= RD_IDLE;
      skid0_q      <= '0;
      skid1_q      <= '0;
      skid_cnt_q   <= 2'd0;
      rd_pending_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      wr_commit_q  <= wr_commit_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_count_q  <= pkt_count_d;
      discard_q    <= discard_d;
      drop_pulse_q <= drop_pulse_d;
      en_q         <= 1'b1;
      state_q      <= state_d;
      skid0_q      <= skid0_d;
      skid1_q      <= skid1_d;
      skid_cnt_q   <= skid_cnt_d;
      rd_pending_q <= rd_pending_d;
    end
  end

  assign pkt_count  = pkt_count_q;
  assign drop_pulse = drop_pulse_q;

  sdp_ram #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data ({s_last, s_data}),
    .rd_en   (fetch),
    .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data (ram_rd_data)
  );

endmodule
